// File: rtl/itch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itch_pkg                                                     |
// | Description : Shared definitions for the ITCH 5.0 Stock Directory ('R')    |
// |               decoder: message length, field offsets, legal code sets,     |
// |               the decoded record layout and the code-set checker.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package itch_pkg;

    // Message geometry (byte offsets from the start of the message)
    localparam int c_msg_len               = 39;
    localparam int c_off_type              = 0;
    localparam int c_off_locate            = 1;
    localparam int c_off_tracking          = 3;
    localparam int c_off_timestamp         = 5;
    localparam int c_off_stock             = 11;
    localparam int c_off_market_cat        = 19;
    localparam int c_off_fin_status        = 20;
    localparam int c_off_round_lot_size    = 21;
    localparam int c_off_round_lots_only   = 25;
    localparam int c_off_issue_class       = 26;
    localparam int c_off_issue_subtype     = 27;
    localparam int c_off_authenticity      = 29;
    localparam int c_off_sst_ind           = 30;
    localparam int c_off_ipo_flag          = 31;
    localparam int c_off_luld_tier         = 32;
    localparam int c_off_etp_flag          = 33;
    localparam int c_off_etp_leverage      = 34;
    localparam int c_off_inverse_ind       = 38;

    localparam logic [7:0] c_type_stock_dir = 8'h52;  // "R"

    // Legal code sets
    typedef enum logic [7:0] {
        DIR_MKT_Q     = 8'h51,
        DIR_MKT_G     = 8'h47,
        DIR_MKT_S     = 8'h53,
        DIR_MKT_N     = 8'h4E,
        DIR_MKT_A     = 8'h41,
        DIR_MKT_P     = 8'h50,
        DIR_MKT_Z     = 8'h5A,
        DIR_MKT_V     = 8'h56,
        DIR_MKT_SPACE = 8'h20
    } dir_market_cat_e;

    typedef enum logic [7:0] {
        DIR_FIN_D     = 8'h44,
        DIR_FIN_E     = 8'h45,
        DIR_FIN_Q     = 8'h51,
        DIR_FIN_S     = 8'h53,
        DIR_FIN_G     = 8'h47,
        DIR_FIN_H     = 8'h48,
        DIR_FIN_J     = 8'h4A,
        DIR_FIN_K     = 8'h4B,
        DIR_FIN_C     = 8'h43,
        DIR_FIN_N     = 8'h4E,
        DIR_FIN_SPACE = 8'h20
    } dir_fin_status_e;

    typedef enum logic [7:0] {
        DIR_YN_Y = 8'h59,
        DIR_YN_N = 8'h4E
    } dir_yn_e;

    typedef enum logic [7:0] {
        DIR_YNS_Y     = 8'h59,
        DIR_YNS_N     = 8'h4E,
        DIR_YNS_SPACE = 8'h20
    } dir_yns_e;

    typedef enum logic [7:0] {
        DIR_AUTH_P = 8'h50,
        DIR_AUTH_T = 8'h54
    } dir_authenticity_e;

    typedef enum logic [7:0] {
        DIR_LULD_1     = 8'h31,
        DIR_LULD_2     = 8'h32,
        DIR_LULD_SPACE = 8'h20
    } dir_luld_e;

    // Decoded record. Fields are in wire order with every multi-byte field
    // big-endian, so the packed struct is exactly bytes 1..38 concatenated.
    typedef struct packed {
        logic [15:0] locate;
        logic [15:0] tracking;
        logic [47:0] timestamp;
        logic [63:0] stock;
        logic [7:0]  market_cat;
        logic [7:0]  fin_status;
        logic [31:0] round_lot_size;
        logic [7:0]  round_lots_only;
        logic [7:0]  issue_class;
        logic [15:0] issue_subtype;
        logic [7:0]  authenticity;
        logic [7:0]  sst_ind;
        logic [7:0]  ipo_flag;
        logic [7:0]  luld_tier;
        logic [7:0]  etp_flag;
        logic [31:0] etp_leverage;
        logic [7:0]  inverse_ind;
    } itch_dir_rec_t;

    // Returns one bit per enumerated field, set when the byte is outside its
    // legal set. Bit 0 = market_cat ... bit 8 = inverse.
    function automatic logic [8:0] dir_code_check(
        input logic [7:0] market_cat,
        input logic [7:0] fin_status,
        input logic [7:0] round_lots_only,
        input logic [7:0] authenticity,
        input logic [7:0] sst_ind,
        input logic [7:0] ipo_flag,
        input logic [7:0] luld_tier,
        input logic [7:0] etp_flag,
        input logic [7:0] inverse_ind
    );
        logic [8:0] v_err;
        v_err    = '0;
        v_err[0] = !(market_cat inside {DIR_MKT_Q, DIR_MKT_G, DIR_MKT_S, DIR_MKT_N,
                                        DIR_MKT_A, DIR_MKT_P, DIR_MKT_Z, DIR_MKT_V,
                                        DIR_MKT_SPACE});
        v_err[1] = !(fin_status inside {DIR_FIN_D, DIR_FIN_E, DIR_FIN_Q, DIR_FIN_S,
                                        DIR_FIN_G, DIR_FIN_H, DIR_FIN_J, DIR_FIN_K,
                                        DIR_FIN_C, DIR_FIN_N, DIR_FIN_SPACE});
        v_err[2] = !(round_lots_only inside {DIR_YN_Y, DIR_YN_N});
        v_err[3] = !(authenticity inside {DIR_AUTH_P, DIR_AUTH_T});
        v_err[4] = !(sst_ind inside {DIR_YNS_Y, DIR_YNS_N, DIR_YNS_SPACE});
        v_err[5] = !(ipo_flag inside {DIR_YNS_Y, DIR_YNS_N, DIR_YNS_SPACE});
        v_err[6] = !(luld_tier inside {DIR_LULD_1, DIR_LULD_2, DIR_LULD_SPACE});
        v_err[7] = !(etp_flag inside {DIR_YNS_Y, DIR_YNS_N, DIR_YNS_SPACE});
        v_err[8] = !(inverse_ind inside {DIR_YN_Y, DIR_YN_N});
        return v_err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/itch_lane_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itch_lane_writer                                             |
// | Description : Maps the valid lanes of one input beat onto absolute message |
// |               offsets, given the number of bytes already received.         |
// |   i_beat_en    : beat is accepted in the collecting state                  |
// |   i_byte_cnt   : bytes of this message received before this beat           |
// |   i_keep/i_data: lane valids / lane bytes of the beat                      |
// |   o_wr_en      : per-offset write enable (offset 0 .. NUM_OFFSETS-1)       |
// |   o_wr_data    : per-offset byte, offset k in bits [8k+7:8k]               |
// |   o_beat_bytes : number of valid lanes in the beat                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module itch_lane_writer #(
    parameter int DATA_BYTES  = 1,
    parameter int NUM_OFFSETS = 39
) (
    input  logic                     i_beat_en,
    input  logic [5:0]               i_byte_cnt,
    input  logic [DATA_BYTES-1:0]    i_keep,
    input  logic [8*DATA_BYTES-1:0]  i_data,
    output logic [NUM_OFFSETS-1:0]   o_wr_en,
    output logic [8*NUM_OFFSETS-1:0] o_wr_data,
    output logic [3:0]               o_beat_bytes
);

    // Valid lanes are contiguous from lane 0, so a plain popcount is the
    // number of bytes the beat carries.
    logic [3:0] w_pop;
    always_comb begin
        w_pop = 4'd0;
        for (int l = 0; l < DATA_BYTES; l++) begin
            if (i_keep[l]) begin
                w_pop = w_pop + 4'd1;
            end
        end
    end
    assign o_beat_bytes = w_pop;

    // Lane l lands on offset i_byte_cnt + l. The sum is kept 7 bits wide so a
    // saturated count never wraps back onto low offsets.
    for (genvar g_o = 0; g_o < NUM_OFFSETS; g_o++) begin : g_off
        logic       w_hit;
        logic [7:0] w_byte;
        always_comb begin
            w_hit  = 1'b0;
            w_byte = 8'h00;
            for (int l = 0; l < DATA_BYTES; l++) begin
                if (i_beat_en && i_keep[l] &&
                    (({1'b0, i_byte_cnt} + 7'(l)) == 7'(g_o))) begin
                    w_hit  = 1'b1;
                    w_byte = i_data[8*l +: 8];
                end
            end
        end
        assign o_wr_en[g_o]            = w_hit;
        assign o_wr_data[8*g_o +: 8]   = w_byte;
    end

endmodule
`default_nettype wire

// File: rtl/itch_stock_directory_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : itch_stock_directory_decoder                                 |
// | Description : Assembles a framed ITCH 5.0 Stock Directory ('R') message    |
// |               arriving DATA_BYTES per beat into one registered record,     |
// |               with per-field code checks and short/long length flags.      |
// |   clk, rst          : clock, synchronous active-high reset                 |
// |   s_valid/s_ready   : input beat handshake                                 |
// |   s_data/s_keep     : lane bytes (lane 0 earliest) / contiguous lane valids|
// |   s_last            : final beat of a message                              |
// |   m_valid/m_ready   : record handshake                                     |
// |   m_<field>         : decoded record fields                                |
// |   m_code_err        : illegal code per field (bit0 market_cat..bit8 inv.)  |
// |   m_len_err         : bit0 short, bit1 long                                |
// | Optional    : define ITCH_DIR_STATS_EN for stat_records / stat_errors /    |
// |               stat_drops 32-bit wrapping counters.                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module itch_stock_directory_decoder #(
    parameter int DATA_BYTES = 1,
    parameter int MSG_LEN    = 39
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [15:0]             m_locate,
    output logic [15:0]             m_tracking,
    output logic [47:0]             m_timestamp,
    output logic [63:0]             m_stock,
    output logic [7:0]              m_market_cat,
    output logic [7:0]              m_fin_status,
    output logic [31:0]             m_round_lot_size,
    output logic [7:0]              m_round_lots_only,
    output logic [7:0]              m_issue_class,
    output logic [15:0]             m_issue_subtype,
    output logic [7:0]              m_authenticity,
    output logic [7:0]              m_sst_ind,
    output logic [7:0]              m_ipo_flag,
    output logic [7:0]              m_luld_tier,
    output logic [7:0]              m_etp_flag,
    output logic [31:0]             m_etp_leverage,
    output logic [7:0]              m_inverse_ind,
    output logic [8:0]              m_code_err,
`ifdef ITCH_DIR_STATS_EN
    output logic [1:0]              m_len_err,
    output logic [31:0]             stat_records,
    output logic [31:0]             stat_errors,
    output logic [31:0]             stat_drops
`else
    output logic [1:0]              m_len_err
`endif
);
    import itch_pkg::*;

    // Payload bytes held in the assembly buffer (offsets 1..38); byte 0 is
    // only ever inspected for the message type.
    localparam int         c_pay_bytes = c_msg_len - 1;
    localparam logic [6:0] c_len       = 7'(MSG_LEN);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_DROP    = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [5:0]               r_byte_cnt;
    logic [5:0]               w_cnt_nxt;
    logic [6:0]               w_cnt_sum;
    // Offset 1 lives in the top byte so the buffer reads as an itch_dir_rec_t.
    logic [8*c_pay_bytes-1:0] r_buf;
    logic [8*c_pay_bytes-1:0] w_buf_nxt;
    logic [c_msg_len-1:0]     w_wr_en;
    logic [8*c_msg_len-1:0]   w_wr_data;
    logic [3:0]               w_beat_bytes;
    logic                     w_collect_beat;
    logic                     w_bad_type;
    itch_dir_rec_t            w_rec;
    itch_dir_rec_t            r_rec;
    logic [8:0]               w_code_err;
    logic [8:0]               r_code_err;
    logic [1:0]               w_len_err;
    logic [1:0]               r_len_err;

    // A beat is only consumed into the record while collecting; in DROP it
    // is accepted but discarded.
    assign w_collect_beat = s_valid && (r_state == S_COLLECT);

    itch_lane_writer #(
        .DATA_BYTES  (DATA_BYTES),
        .NUM_OFFSETS (c_msg_len)
    ) u_lane_writer (
        .i_beat_en    (w_collect_beat),
        .i_byte_cnt   (r_byte_cnt),
        .i_keep       (s_keep),
        .i_data       (s_data),
        .o_wr_en      (w_wr_en),
        .o_wr_data    (w_wr_data),
        .o_beat_bytes (w_beat_bytes)
    );

    // Byte count saturates at 63 so very long messages still read as long.
    assign w_cnt_sum = {1'b0, r_byte_cnt} + {3'b000, w_beat_bytes};
    assign w_cnt_nxt = (w_cnt_sum > 7'd63) ? 6'd63 : w_cnt_sum[5:0];

    assign w_bad_type = w_wr_en[c_off_type] &&
                        (w_wr_data[8*c_off_type +: 8] != c_type_stock_dir);

    always_comb begin
        w_buf_nxt = r_buf;
        for (int o = 1; o < c_msg_len; o++) begin
            if (w_wr_en[o]) begin
                w_buf_nxt[8*(c_msg_len-1-o) +: 8] = w_wr_data[8*o +: 8];
            end
        end
    end

    assign w_rec      = itch_dir_rec_t'(w_buf_nxt);
    assign w_code_err = dir_code_check(w_rec.market_cat, w_rec.fin_status,
                                       w_rec.round_lots_only, w_rec.authenticity,
                                       w_rec.sst_ind, w_rec.ipo_flag,
                                       w_rec.luld_tier, w_rec.etp_flag,
                                       w_rec.inverse_ind);
    assign w_len_err  = {({1'b0, w_cnt_nxt} > c_len), ({1'b0, w_cnt_nxt} < c_len)};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b1;
        m_valid     = 1'b0;
        case (r_state)
            S_COLLECT: begin
                if (s_valid) begin
                    if (w_bad_type) begin
                        // A one-beat foreign message is already framed.
                        w_state_nxt = s_last ? S_COLLECT : S_DROP;
                    end else if (s_last) begin
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                s_ready = 1'b0;
                m_valid = 1'b1;
                if (m_ready) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            S_DROP: begin
                if (s_valid && s_last) begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Assembly buffer and output record. The buffer is cleared whenever a
    // message ends (or is dropped) so bytes never received read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_buf      <= '0;
            r_rec      <= '0;
            r_code_err <= '0;
            r_len_err  <= '0;
        end else if (w_collect_beat) begin
            if (w_bad_type || s_last) begin
                r_byte_cnt <= '0;
                r_buf      <= '0;
            end else begin
                r_byte_cnt <= w_cnt_nxt;
                r_buf      <= w_buf_nxt;
            end
            if (s_last && !w_bad_type) begin
                r_rec      <= w_rec;
                r_code_err <= w_code_err;
                r_len_err  <= w_len_err;
            end
        end
    end

    assign m_locate          = r_rec.locate;
    assign m_tracking        = r_rec.tracking;
    assign m_timestamp       = r_rec.timestamp;
    assign m_stock           = r_rec.stock;
    assign m_market_cat      = r_rec.market_cat;
    assign m_fin_status      = r_rec.fin_status;
    assign m_round_lot_size  = r_rec.round_lot_size;
    assign m_round_lots_only = r_rec.round_lots_only;
    assign m_issue_class     = r_rec.issue_class;
    assign m_issue_subtype   = r_rec.issue_subtype;
    assign m_authenticity    = r_rec.authenticity;
    assign m_sst_ind         = r_rec.sst_ind;
    assign m_ipo_flag        = r_rec.ipo_flag;
    assign m_luld_tier       = r_rec.luld_tier;
    assign m_etp_flag        = r_rec.etp_flag;
    assign m_etp_leverage    = r_rec.etp_leverage;
    assign m_inverse_ind     = r_rec.inverse_ind;
    assign m_code_err        = r_code_err;
    assign m_len_err         = r_len_err;

`ifdef ITCH_DIR_STATS_EN
    logic [31:0] r_stat_records;
    logic [31:0] r_stat_errors;
    logic [31:0] r_stat_drops;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_records <= '0;
            r_stat_errors  <= '0;
            r_stat_drops   <= '0;
        end else begin
            if (m_valid && m_ready) begin
                r_stat_records <= r_stat_records + 32'd1;
                if ((|r_code_err) || (|r_len_err)) begin
                    r_stat_errors <= r_stat_errors + 32'd1;
                end
            end
            if (w_collect_beat && w_bad_type) begin
                r_stat_drops <= r_stat_drops + 32'd1;
            end
        end
    end

    assign stat_records = r_stat_records;
    assign stat_errors  = r_stat_errors;
    assign stat_drops   = r_stat_drops;
`endif

endmodule
`default_nettype wire

// File: tb/tb_itch_stock_directory_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_itch_stock_directory_decoder                              |
// | Description : Self-checking bench for itch_stock_directory_decoder. Two    |
// |               instances (1-byte and 8-byte lanes) are driven with directed |
// |               and random messages and compared against a byte-level model. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_itch_stock_directory_decoder;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [1:0]           s_valid, s_ready, s_last, m_valid, m_ready;
    logic [1:0][63:0]     s_data;
    logic [1:0][7:0]      s_keep;
    logic [1:0][15:0]     m_locate, m_tracking, m_issue_subtype;
    logic [1:0][47:0]     m_timestamp;
    logic [1:0][63:0]     m_stock;
    logic [1:0][31:0]     m_round_lot_size, m_etp_leverage;
    logic [1:0][7:0]      m_market_cat, m_fin_status, m_round_lots_only, m_issue_class;
    logic [1:0][7:0]      m_authenticity, m_sst_ind, m_ipo_flag, m_luld_tier;
    logic [1:0][7:0]      m_etp_flag, m_inverse_ind;
    logic [1:0][8:0]      m_code_err;
    logic [1:0][1:0]      m_len_err;
`ifdef ITCH_DIR_STATS_EN
    logic [1:0][31:0]     stat_records, stat_errors, stat_drops;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_recs [2] = '{0, 0};
    int n_errs [2] = '{0, 0};
    int n_drops[2] = '{0, 0};

    int    c_off[9] = '{19, 20, 25, 29, 30, 31, 32, 33, 38};
    string c_set[9] = '{"QGSNAPZV ", "DEQSGHJKCN ", "YN", "PT", "YN ", "YN ", "12 ", "YN ", "YN"};

    itch_stock_directory_decoder #(.DATA_BYTES(1), .MSG_LEN(39)) u_dut_b1 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0][7:0]),
        .s_keep(s_keep[0][0:0]), .s_last(s_last[0]),
        .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .m_locate(m_locate[0]), .m_tracking(m_tracking[0]), .m_timestamp(m_timestamp[0]),
        .m_stock(m_stock[0]), .m_market_cat(m_market_cat[0]), .m_fin_status(m_fin_status[0]),
        .m_round_lot_size(m_round_lot_size[0]), .m_round_lots_only(m_round_lots_only[0]),
        .m_issue_class(m_issue_class[0]), .m_issue_subtype(m_issue_subtype[0]),
        .m_authenticity(m_authenticity[0]), .m_sst_ind(m_sst_ind[0]), .m_ipo_flag(m_ipo_flag[0]),
        .m_luld_tier(m_luld_tier[0]), .m_etp_flag(m_etp_flag[0]),
        .m_etp_leverage(m_etp_leverage[0]), .m_inverse_ind(m_inverse_ind[0]),
        .m_code_err(m_code_err[0]),
`ifdef ITCH_DIR_STATS_EN
        .m_len_err(m_len_err[0]),
        .stat_records(stat_records[0]), .stat_errors(stat_errors[0]), .stat_drops(stat_drops[0])
`else
        .m_len_err(m_len_err[0])
`endif
    );

    itch_stock_directory_decoder #(.DATA_BYTES(8), .MSG_LEN(39)) u_dut_b8 (
        .clk(clk), .rst(rst),
        .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
        .s_keep(s_keep[1]), .s_last(s_last[1]),
        .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .m_locate(m_locate[1]), .m_tracking(m_tracking[1]), .m_timestamp(m_timestamp[1]),
        .m_stock(m_stock[1]), .m_market_cat(m_market_cat[1]), .m_fin_status(m_fin_status[1]),
        .m_round_lot_size(m_round_lot_size[1]), .m_round_lots_only(m_round_lots_only[1]),
        .m_issue_class(m_issue_class[1]), .m_issue_subtype(m_issue_subtype[1]),
        .m_authenticity(m_authenticity[1]), .m_sst_ind(m_sst_ind[1]), .m_ipo_flag(m_ipo_flag[1]),
        .m_luld_tier(m_luld_tier[1]), .m_etp_flag(m_etp_flag[1]),
        .m_etp_leverage(m_etp_leverage[1]), .m_inverse_ind(m_inverse_ind[1]),
        .m_code_err(m_code_err[1]),
`ifdef ITCH_DIR_STATS_EN
        .m_len_err(m_len_err[1]),
        .stat_records(stat_records[1]), .stat_errors(stat_errors[1]), .stat_drops(stat_drops[1])
`else
        .m_len_err(m_len_err[1])
`endif
    );

    // ---------------- reference model ----------------
    function automatic byte unsigned at(input bq_t m, input int o);
        return (o < m.size()) ? m[o] : 8'h00;
    endfunction

    // All record fields are big-endian and contiguous, so the expected
    // record is simply bytes 1..38 in order (missing bytes read as zero).
    function automatic logic [303:0] exp_fields(input bq_t m);
        logic [303:0] v;
        v = '0;
        for (int i = 1; i <= 38; i++) v = {v[295:0], at(m, i)};
        return v;
    endfunction

    function automatic bit in_set(input byte unsigned b, input string s);
        for (int i = 0; i < s.len(); i++) if (s[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [8:0] exp_code(input bq_t m);
        logic [8:0] e;
        e = '0;
        for (int k = 0; k < 9; k++) e[k] = !in_set(at(m, c_off[k]), c_set[k]);
        return e;
    endfunction

    function automatic logic [1:0] exp_len(input bq_t m);
        return {m.size() > 39, m.size() < 39};
    endfunction

    function automatic logic [303:0] dut_fields(input int w);
        return {m_locate[w], m_tracking[w], m_timestamp[w], m_stock[w], m_market_cat[w],
                m_fin_status[w], m_round_lot_size[w], m_round_lots_only[w], m_issue_class[w],
                m_issue_subtype[w], m_authenticity[w], m_sst_ind[w], m_ipo_flag[w],
                m_luld_tier[w], m_etp_flag[w], m_etp_leverage[w], m_inverse_ind[w]};
    endfunction

    function automatic bq_t aapl_msg();
        bq_t m;
        byte unsigned b[39] = '{8'h52, 8'h00, 8'h42, 8'h00, 8'h07,
                                8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                8'h41, 8'h41, 8'h50, 8'h4C, 8'h20, 8'h20, 8'h20, 8'h20,
                                8'h51, 8'h4E, 8'h00, 8'h00, 8'h00, 8'h64, 8'h4E, 8'h43,
                                8'h5A, 8'h20, 8'h50, 8'h4E, 8'h20, 8'h31, 8'h4E,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h4E};
        foreach (b[i]) m.push_back(b[i]);
        return m;
    endfunction

    function automatic bq_t rand_msg(input int len);
        bq_t   m;
        string s;
        for (int i = 0; i < len; i++) m.push_back(8'($urandom));
        m[0] = ($urandom_range(99) < 80) ? 8'h52 : 8'h41 + 8'($urandom_range(16));
        for (int k = 0; k < 9; k++) begin
            if (c_off[k] < len && $urandom_range(5) != 0) begin
                s = c_set[k];
                m[c_off[k]] = s[$urandom_range(s.len() - 1)];
            end
        end
        return m;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [303:0] obs, input logic [303:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    // Drives message bytes on instance w; on return we sit at the negedge
    // one cycle after the final beat was accepted.
    task automatic send_msg(input int w, input bq_t m, input bit gaps, input bit with_last);
        int lanes;
        int nb;
        lanes = (w == 0) ? 1 : 8;
        nb    = (m.size() + lanes - 1) / lanes;
        for (int b = 0; b < nb; b++) begin
            if (gaps && $urandom_range(3) == 0) begin
                @(negedge clk);
                s_valid[w] = 1'b0;
            end
            if (gaps && $urandom_range(5) == 0) begin
                @(negedge clk);
                s_valid[w] = 1'b1;
                s_keep[w]  = '0;
                s_last[w]  = 1'b0;
                s_data[w]  = {$urandom, $urandom};
            end
            @(negedge clk);
            s_valid[w] = 1'b1;
            s_data[w]  = {$urandom, $urandom};
            s_keep[w]  = '0;
            for (int l = 0; l < lanes; l++) begin
                if (b * lanes + l < m.size()) begin
                    s_data[w][8*l +: 8] = m[b * lanes + l];
                    s_keep[w][l]        = 1'b1;
                end
            end
            s_last[w] = with_last && (b == nb - 1);
        end
        @(negedge clk);
        s_valid[w] = 1'b0;
        s_last[w]  = 1'b0;
        s_keep[w]  = '0;
    endtask

    task automatic finish_msg(input int w, input bq_t m, input int hold);
        bit           rec;
        logic [303:0] ef;
        logic [8:0]   ec;
        logic [1:0]   el;
        rec = (m[0] == 8'h52);
        ef  = exp_fields(m);
        ec  = exp_code(m);
        el  = exp_len(m);
        chk($sformatf("dut%0d m_valid after last", w), 304'(m_valid[w]), 304'(rec));
        if (rec) begin
            chk($sformatf("dut%0d fields", w), dut_fields(w), ef);
            chk($sformatf("dut%0d code_err", w), 304'(m_code_err[w]), 304'(ec));
            chk($sformatf("dut%0d len_err", w), 304'(m_len_err[w]), 304'(el));
            chk($sformatf("dut%0d s_ready in hold", w), 304'(s_ready[w]), 304'(0));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                chk($sformatf("dut%0d hold m_valid", w), 304'(m_valid[w]), 304'(1));
                chk($sformatf("dut%0d hold fields", w), dut_fields(w), ef);
            end
            m_ready[w] = 1'b1;
            @(negedge clk);
            m_ready[w] = 1'b0;
            chk($sformatf("dut%0d m_valid after handshake", w), 304'(m_valid[w]), 304'(0));
            chk($sformatf("dut%0d s_ready after handshake", w), 304'(s_ready[w]), 304'(1));
            n_recs[w]++;
            if (ec != 0 || el != 0) n_errs[w]++;
        end else begin
            n_drops[w]++;
        end
    endtask

    task automatic chk_stats(input int w);
`ifdef ITCH_DIR_STATS_EN
        chk($sformatf("dut%0d stat_records", w), 304'(stat_records[w]), 304'(n_recs[w]));
        chk($sformatf("dut%0d stat_errors", w), 304'(stat_errors[w]), 304'(n_errs[w]));
        chk($sformatf("dut%0d stat_drops", w), 304'(stat_drops[w]), 304'(n_drops[w]));
`endif
    endtask

    initial begin
        bq_t base;
        bq_t m;
        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_keep  = '0;
        s_data  = '0;
        m_ready = '0;
        repeat (3) @(negedge clk);

        // Reset state
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("dut%0d reset m_valid", w), 304'(m_valid[w]), 304'(0));
            chk($sformatf("dut%0d reset s_ready", w), 304'(s_ready[w]), 304'(1));
            chk($sformatf("dut%0d reset fields", w), dut_fields(w), '0);
            chk($sformatf("dut%0d reset errs", w), 304'({m_code_err[w], m_len_err[w]}), 304'(0));
        end
        rst = 1'b0;

        base = aapl_msg();
        for (int w = 0; w < 2; w++) begin
            // Clean message
            send_msg(w, base, 1'b0, 1'b1);
            chk($sformatf("dut%0d aapl locate", w), 304'(m_locate[w]), 304'(16'h0042));
            chk($sformatf("dut%0d aapl stock", w), 304'(m_stock[w]), 304'(64'h4141504C20202020));
            finish_msg(w, base, 0);

            // Illegal market and authenticity codes
            m = base;
            m[19] = 8'h58;
            m[29] = 8'h5A;
            send_msg(w, m, 1'b0, 1'b1);
            chk($sformatf("dut%0d X/Z code_err", w), 304'(m_code_err[w]), 304'(9'b000001001));
            finish_msg(w, m, 0);

            // Short (30 bytes) and long (42 bytes)
            m = base[0:29];
            send_msg(w, m, 1'b0, 1'b1);
            chk($sformatf("dut%0d short len_err", w), 304'(m_len_err[w]), 304'(2'b01));
            finish_msg(w, m, 0);
            m = base;
            m.push_back(8'h11); m.push_back(8'h22); m.push_back(8'h33);
            send_msg(w, m, 1'b0, 1'b1);
            chk($sformatf("dut%0d long len_err", w), 304'(m_len_err[w]), 304'(2'b10));
            finish_msg(w, m, 0);

            // Foreign type then a valid message
            m = base;
            m[0] = 8'h41;
            send_msg(w, m, 1'b0, 1'b1);
            finish_msg(w, m, 0);
`ifdef ITCH_DIR_STATS_EN
            chk($sformatf("dut%0d first drop", w), 304'(stat_drops[w]), 304'(1));
`endif
            send_msg(w, base, 1'b0, 1'b1);
            finish_msg(w, base, 10);
            chk_stats(w);
        end

        // Reset in the middle of a message discards it
        send_msg(0, base[0:11], 1'b0, 1'b0);
        send_msg(1, base[0:15], 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_recs  = '{0, 0};
        n_errs  = '{0, 0};
        n_drops = '{0, 0};
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("dut%0d m_valid after mid rst", w), 304'(m_valid[w]), 304'(0));
            send_msg(w, base, 1'b0, 1'b1);
            finish_msg(w, base, 0);
        end

        // Random traffic
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 30; i++) begin
                m = rand_msg($urandom_range(1, 50));
                send_msg(w, m, 1'b1, 1'b1);
                finish_msg(w, m, $urandom_range(0, 3));
            end
            chk_stats(w);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
